// File: rtl/pb_gesture_pkg.sv
// Shared types and helpers for the push-button gesture controller.
// Gesture codes match the values that appear on the event port.
package pb_gesture_pkg;

  typedef enum logic [2:0] {
    GC_NONE     = 3'd0,
    GC_SHORT    = 3'd1,
    GC_DOUBLE   = 3'd2,
    GC_LONG     = 3'd3,
    GC_REPEAT   = 3'd4,
    GC_LONG_END = 3'd5
  } gesture_code_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD  = 3'd1,
    ST_RPT   = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_HELD2 = 3'd4
  } state_t;

  localparam int MAX_BTN = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_gesture_chan.sv
// One button's gesture classifier: FSM, saturating tick timer and a
// single-entry pending event slot with a sticky overflow flag.
module pb_gesture_chan
  import pb_gesture_pkg::*;
#(
  parameter int LONG_TICKS   = 800,
  parameter int DCLICK_TICKS = 250,
  parameter int REPEAT_TICKS = 150
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic          i_press,
  input  logic          i_rel,
  input  logic          i_grant,
  output logic          o_slot_full,
  output gesture_code_t o_slot_code,
  output logic          o_overflow
);

  localparam int TW = $clog2(max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS) + 1);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_TICKS - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);
  localparam logic [TW-1:0] TIMER_SAT   = {TW{1'b1}};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [TW-1:0] timer_r;
  logic          timer_clr_s;
  logic          emit_s;
  gesture_code_t emit_code_s;
  logic          press_s;
  logic          rel_s;
  logic          slot_full_r;
  gesture_code_t slot_code_r;
  logic          overflow_r;

  // Simultaneous press and release cancel each other out.
  assign press_s = i_press & ~i_rel;
  assign rel_s   = i_rel & ~i_press;

  // Classification: next state, timer clear and gesture to emit.
  always_comb begin
    state_nxt_s = state_r;
    timer_clr_s = 1'b0;
    emit_s      = 1'b0;
    emit_code_s = GC_NONE;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_nxt_s = ST_HELD;
          timer_clr_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (rel_s) begin
          state_nxt_s = ST_WAIT2;
          timer_clr_s = 1'b1;
        end else if (i_tick && (timer_r == LONG_LAST)) begin
          state_nxt_s = ST_RPT;
          timer_clr_s = 1'b1;
          emit_s      = 1'b1;
          emit_code_s = GC_LONG;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_RPT: begin
        if (rel_s) begin
          state_nxt_s = ST_IDLE;
          timer_clr_s = 1'b1;
          emit_s      = 1'b1;
          emit_code_s = GC_LONG_END;
        end else if (i_tick && (timer_r == REPEAT_LAST)) begin
          timer_clr_s = 1'b1;
          emit_s      = 1'b1;
          emit_code_s = GC_REPEAT;
        end else begin
          state_nxt_s = ST_RPT;
        end
      end
      ST_WAIT2: begin
        if (press_s) begin
          state_nxt_s = ST_HELD2;
          timer_clr_s = 1'b1;
          emit_s      = 1'b1;
          emit_code_s = GC_DOUBLE;
        end else if (i_tick && (timer_r == DCLICK_LAST)) begin
          state_nxt_s = ST_IDLE;
          timer_clr_s = 1'b1;
          emit_s      = 1'b1;
          emit_code_s = GC_SHORT;
        end else begin
          state_nxt_s = ST_WAIT2;
        end
      end
      ST_HELD2: begin
        if (rel_s) begin
          state_nxt_s = ST_IDLE;
          timer_clr_s = 1'b1;
        end else begin
          state_nxt_s = ST_HELD2;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_clr_s = 1'b1;
      end
    endcase
  end

  // State register and saturating tick timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      timer_r <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (timer_clr_s) begin
        timer_r <= {TW{1'b0}};
      end else if (i_tick && (timer_r != TIMER_SAT)) begin
        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Pending slot: a grant frees it in time to accept a same-cycle emit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_full_r <= 1'b0;
      slot_code_r <= GC_NONE;
      overflow_r  <= 1'b0;
    end else if (emit_s && (!slot_full_r || i_grant)) begin
      slot_full_r <= 1'b1;
      slot_code_r <= emit_code_s;
    end else if (emit_s) begin
      overflow_r  <= 1'b1;
    end else if (i_grant) begin
      slot_full_r <= 1'b0;
    end
  end

  assign o_slot_full = slot_full_r;
  assign o_slot_code = slot_code_r;
  assign o_overflow  = overflow_r;

endmodule

// File: rtl/pb_gesture_ctrl.sv
// Gesture controller top: shared tick prescaler, per-button classifiers and a
// round-robin arbiter feeding one registered valid/ready event port.
module pb_gesture_ctrl
  import pb_gesture_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 800,
  parameter int DCLICK_TICKS = 250,
  parameter int REPEAT_TICKS = 150
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_pressed_pulse,
  input  logic [N_BTN-1:0] i_released_pulse,
  input  logic             i_evt_ready,
  output logic             o_evt_valid,
  output logic [2:0]       o_evt_btn,
  output logic [2:0]       o_evt_code,
  output logic [N_BTN-1:0] o_overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    BTN_LAST = 3'(N_BTN - 1);

  logic [PW-1:0]      pre_cnt_r;
  logic               tick_s;
  logic [MAX_BTN-1:0] slot_full_s;
  gesture_code_t      slot_code_s [MAX_BTN];
  logic [N_BTN-1:0]   grant_s;
  logic [2:0]         rr_ptr_r;
  logic [2:0]         pick_s;
  logic               pick_found_s;
  logic               load_en_s;
  logic               evt_valid_r;
  logic [2:0]         evt_btn_r;
  logic [2:0]         evt_code_r;

  function automatic logic [2:0] rr_index(input logic [2:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    s = (s >= unsigned'(N_BTN)) ? (s - unsigned'(N_BTN)) : s;
    return s[2:0];
  endfunction

  assign tick_s = (pre_cnt_r == PRE_LAST);

  // Tick prescaler shared by every channel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt_r <= {PW{1'b0}};
    end else if (tick_s) begin
      pre_cnt_r <= {PW{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < MAX_BTN; g++) begin : g_btn
    if (g < N_BTN) begin : g_chan
      pb_gesture_chan #(
        .LONG_TICKS   (LONG_TICKS),
        .DCLICK_TICKS (DCLICK_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
      ) u_chan (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tick      (tick_s),
        .i_press     (i_pressed_pulse[g]),
        .i_rel       (i_released_pulse[g]),
        .i_grant     (grant_s[g]),
        .o_slot_full (slot_full_s[g]),
        .o_slot_code (slot_code_s[g]),
        .o_overflow  (o_overflow[g])
      );
    end else begin : g_pad
      assign slot_full_s[g] = 1'b0;
      assign slot_code_s[g] = GC_NONE;
    end
  end

  assign load_en_s = ~evt_valid_r | i_evt_ready;

  // First occupied slot at or after the round-robin pointer.
  always_comb begin
    pick_found_s = 1'b0;
    pick_s       = 3'd0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!pick_found_s && slot_full_s[rr_index(rr_ptr_r, unsigned'(k))]) begin
        pick_found_s = 1'b1;
        pick_s       = rr_index(rr_ptr_r, unsigned'(k));
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // One-hot grant, only when the output register can take a new event.
  always_comb begin
    grant_s = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      grant_s[i] = load_en_s & pick_found_s & (pick_s == 3'(i));
    end
  end

  // Output event register and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      evt_valid_r <= 1'b0;
      evt_btn_r   <= 3'd0;
      evt_code_r  <= 3'd0;
      rr_ptr_r    <= 3'd0;
    end else if (load_en_s) begin
      if (pick_found_s) begin
        evt_valid_r <= 1'b1;
        evt_btn_r   <= pick_s;
        evt_code_r  <= slot_code_s[pick_s];
        rr_ptr_r    <= (pick_s == BTN_LAST) ? 3'd0 : (pick_s + 3'd1);
      end else begin
        evt_valid_r <= 1'b0;
        evt_btn_r   <= 3'd0;
        evt_code_r  <= 3'd0;
      end
    end
  end

  assign o_evt_valid = evt_valid_r;
  assign o_evt_btn   = evt_btn_r;
  assign o_evt_code  = evt_code_r;

endmodule

// File: tb/tb_pb_gesture_ctrl.sv
// Self-checking bench for pb_gesture_ctrl: timestamp-based gesture model plus
// per-cycle output comparison and directed scenario expectations.
module tb_pb_gesture_ctrl;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int LT = 10;
  localparam int DT = 5;
  localparam int RT = 3;

  localparam int C_SHORT = 1, C_DOUBLE = 2, C_LONG = 3, C_REPEAT = 4, C_LEND = 5;
  localparam int P_UP = 0, P_DOWN = 1, P_WAIT = 2, P_DOWN2 = 3, P_REP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] press_p = '0;
  logic [NB-1:0] rel_p = '0;
  logic          rdy = 1'b1;
  logic          evt_valid;
  logic [2:0]    evt_btn;
  logic [2:0]    evt_code;
  logic [NB-1:0] ovf;

  pb_gesture_ctrl #(
    .N_BTN(NB), .TICK_DIV(TD), .LONG_TICKS(LT), .DCLICK_TICKS(DT), .REPEAT_TICKS(RT)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pressed_pulse  (press_p),
    .i_released_pulse (rel_p),
    .i_evt_ready      (rdy),
    .o_evt_valid      (evt_valid),
    .o_evt_btn        (evt_btn),
    .o_evt_code       (evt_code),
    .o_overflow       (ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;
  int lg_btn[$];
  int lg_code[$];
  int lg_cyc[$];

  // model state
  int m_ph[NB];
  int m_t0[NB];
  int m_tk, m_cyc;
  bit m_pend_v[NB];
  int m_pend_c[NB];
  bit [NB-1:0] m_ovf;
  bit m_ov;
  int m_ob, m_oc, m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_ph[b] = P_UP; m_t0[b] = 0; m_pend_v[b] = 1'b0; m_pend_c[b] = 0;
    end
    m_ovf = '0; m_ov = 1'b0; m_ob = 0; m_oc = 0; m_ptr = 0; m_tk = 0; m_cyc = 0;
  endtask

  // Advance the model across one rising edge using the inputs the DUT saw.
  task automatic model_step();
    bit tick, ld, pr, rl;
    int g, idx;
    bit e_v[NB];
    int e_c[NB];
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    if (tick) m_tk++;
    for (int b = 0; b < NB; b++) begin
      pr = press_p[b] && !rel_p[b];
      rl = rel_p[b] && !press_p[b];
      e_v[b] = 1'b0; e_c[b] = 0;
      case (m_ph[b])
        P_UP:    if (pr) begin m_ph[b] = P_DOWN; m_t0[b] = m_tk; end
        P_DOWN:  if (rl) begin m_ph[b] = P_WAIT; m_t0[b] = m_tk; end
                 else if (tick && (m_tk - m_t0[b] == LT)) begin
                   e_v[b] = 1'b1; e_c[b] = C_LONG; m_ph[b] = P_REP; m_t0[b] = m_tk;
                 end
        P_REP:   if (rl) begin e_v[b] = 1'b1; e_c[b] = C_LEND; m_ph[b] = P_UP; end
                 else if (tick && (m_tk - m_t0[b] == RT)) begin
                   e_v[b] = 1'b1; e_c[b] = C_REPEAT; m_t0[b] = m_tk;
                 end
        P_WAIT:  if (pr) begin e_v[b] = 1'b1; e_c[b] = C_DOUBLE; m_ph[b] = P_DOWN2; end
                 else if (tick && (m_tk - m_t0[b] == DT)) begin
                   e_v[b] = 1'b1; e_c[b] = C_SHORT; m_ph[b] = P_UP;
                 end
        default: if (rl) m_ph[b] = P_UP;
      endcase
    end
    ld = !m_ov || rdy;
    g = -1;
    if (ld) begin
      for (int k = 0; k < NB; k++) begin
        idx = (m_ptr + k) % NB;
        if (g < 0 && m_pend_v[idx]) g = idx;
      end
      if (g >= 0) begin
        m_ov = 1'b1; m_ob = g; m_oc = m_pend_c[g]; m_pend_v[g] = 1'b0; m_ptr = (g + 1) % NB;
      end else begin
        m_ov = 1'b0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (e_v[b]) begin
        if (m_pend_v[b]) m_ovf[b] = 1'b1;
        else begin m_pend_v[b] = 1'b1; m_pend_c[b] = e_c[b]; end
      end
    end
  endtask

  task automatic cyc(input logic [NB-1:0] pr, input logic [NB-1:0] rl);
    press_p = pr;
    rel_p   = rl;
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
    press_p = '0;
    rel_p   = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  // Per-cycle comparison against the model, plus acceptance logging.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("evt_valid", 32'(evt_valid), 32'(m_ov));
        if (m_ov) begin
          chk("evt_btn", 32'(evt_btn), 32'(m_ob));
          chk("evt_code", 32'(evt_code), 32'(m_oc));
        end
        chk("overflow", 32'(ovf), 32'(m_ovf));
        if (evt_valid && rdy) begin
          lg_btn.push_back(int'(evt_btn));
          lg_code.push_back(int'(evt_code));
          lg_cyc.push_back(cyc_n);
        end
      end
    end
  end

  initial begin
    int s, rc, lat;
    int exp_c[5];
    int exp_b[4];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_btn", 32'(evt_btn), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // short press on btn0
    s = lg_btn.size();
    cyc(4'b0001, '0);
    run(11);
    cyc('0, 4'b0001);
    rc = cyc_n;
    run(30);
    chk("short_cnt", 32'(lg_btn.size() - s), 32'd1);
    chk("short_btn", 32'(lg_btn[s]), 32'd0);
    chk("short_code", 32'(lg_code[s]), 32'(C_SHORT));
    lat = lg_cyc[s] - rc;
    chk("short_latency_ok", 32'(lat <= 5 * TD + 2 && lat > 0), 32'd1);

    // double click on btn1, held long afterwards
    s = lg_btn.size();
    cyc(4'b0010, '0);
    run(7);
    cyc('0, 4'b0010);
    run(7);
    cyc(4'b0010, '0);
    run(80);
    cyc('0, 4'b0010);
    run(40);
    chk("dbl_cnt", 32'(lg_btn.size() - s), 32'd1);
    chk("dbl_btn", 32'(lg_btn[s]), 32'd1);
    chk("dbl_code", 32'(lg_code[s]), 32'(C_DOUBLE));

    // long press with repeats on btn2
    s = lg_btn.size();
    exp_c = '{C_LONG, C_REPEAT, C_REPEAT, C_REPEAT, C_LEND};
    cyc(4'b0100, '0);
    run(79);
    cyc('0, 4'b0100);
    run(10);
    chk("long_cnt", 32'(lg_btn.size() - s), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("long_btn", 32'(lg_btn[s + k]), 32'd2);
      chk("long_code", 32'(lg_code[s + k]), 32'(exp_c[k]));
    end

    // arbitration from pointer 0
    do_reset();
    s = lg_btn.size();
    cyc(4'b1111, '0);
    run(7);
    cyc('0, 4'b1111);
    run(30);
    exp_b = '{0, 1, 2, 3};
    chk("arb0_cnt", 32'(lg_btn.size() - s), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("arb0_btn", 32'(lg_btn[s + k]), 32'(exp_b[k]));
      chk("arb0_code", 32'(lg_code[s + k]), 32'(C_SHORT));
      if (k > 0) chk("arb0_consec", 32'(lg_cyc[s + k] - lg_cyc[s + k - 1]), 32'd1);
    end
    // move the pointer to 2 with a single btn1 short press
    cyc(4'b0010, '0);
    run(3);
    cyc('0, 4'b0010);
    run(30);
    s = lg_btn.size();
    cyc(4'b1111, '0);
    run(7);
    cyc('0, 4'b1111);
    run(30);
    exp_b = '{2, 3, 0, 1};
    chk("arb2_cnt", 32'(lg_btn.size() - s), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("arb2_btn", 32'(lg_btn[s + k]), 32'(exp_b[k]));
      if (k > 0) chk("arb2_consec", 32'(lg_cyc[s + k] - lg_cyc[s + k - 1]), 32'd1);
    end

    // backpressure and overflow on btn2
    rdy = 1'b0;
    cyc(4'b0100, '0);
    run(67);
    chk("bp_valid", 32'(evt_valid), 32'd1);
    chk("bp_btn", 32'(evt_btn), 32'd2);
    chk("bp_code", 32'(evt_code), 32'(C_LONG));
    chk("bp_ovf", 32'(ovf), 32'b0100);
    s = lg_btn.size();
    rdy = 1'b1;
    run(3);
    chk("bp_drain_cnt", 32'(lg_btn.size() - s), 32'd2);
    chk("bp_drain0", 32'(lg_code[s]), 32'(C_LONG));
    chk("bp_drain1", 32'(lg_code[s + 1]), 32'(C_REPEAT));
    chk("bp_drain1_btn", 32'(lg_btn[s + 1]), 32'd2);
    cyc('0, 4'b0100);
    run(10);

    // async reset while btn0 is repeating with events pending
    rdy = 1'b0;
    cyc(4'b0001, '0);
    run(56);
    chk("pre_rst_valid", 32'(evt_valid), 32'd1);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_btn", 32'(evt_btn), 32'd0);
    chk("arst_code", 32'(evt_code), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    rdy = 1'b1;
    s = lg_btn.size();
    run(48);
    chk("arst_quiet", 32'(lg_btn.size() - s), 32'd0);
    cyc(4'b0001, '0);
    run(44);
    chk("arst_long_cnt", 32'(lg_btn.size() - s), 32'd1);
    chk("arst_long_btn", 32'(lg_btn[s]), 32'd0);
    chk("arst_long_code", 32'(lg_code[s]), 32'(C_LONG));
    cyc('0, 4'b0001);
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
